ct_frame_buffer: RTL and testbench
==================================

CT_FRAME_BUFFER -- requirements
Module: ct_frame_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 18, bit width of one Ct element.
REQ-002 Parameter LANES, default 16, Ct elements per written word.
REQ-003 Parameter READ_PORTS, default 2, consecutive words returned per read.
REQ-004 Parameter DEPTH, default 64, words per frame; legal range 2..4096.
REQ-005 Parameter ADDR_WIDTH, default 6, equals ceil(log2(DEPTH)).
REQ-006 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1, asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
REQ-008 Port wen, input, 1, write strobe for i_ct.
REQ-009 Port i_ct, input, LANES*DATA_WIDTH, packed word; lane n is bits [n*DATA_WIDTH +: DATA_WIDTH].
REQ-010 Port ren, input, 1, read request.
REQ-011 Port replay, input, 1, sampled with the final read of a frame; requests re-drain of the same frame.
REQ-012 Port o_ct, output, READ_PORTS*LANES*DATA_WIDTH, port p occupies bits [p*LANES*DATA_WIDTH +: LANES*DATA_WIDTH].
REQ-013 Port o_port_mask, output, READ_PORTS, bit p = 1 when port p holds a real frame word.
REQ-014 Port o_valid, output, 1, one-cycle pulse qualifying o_ct and o_port_mask.
REQ-015 Port o_frame_ready, output, 1, high while state is READY or DRAIN.
REQ-016 Port o_overflow, output, 1, sticky error: wen outside FILL.
REQ-017 Port o_underflow, output, 1, sticky error: ren during FILL.

Function
REQ-018 The block SHALL run a three-state FSM: FILL, READY, DRAIN.
REQ-019 In FILL, each wen SHALL write i_ct to RAM[wptr] and increment wptr; the write at wptr = DEPTH-1 SHALL clear wptr to 0 and move the FSM to READY on the next cycle.
REQ-020 In READY or DRAIN, an accepted ren SHALL read RAM[rptr+p] for every port p, advance rptr by READ_PORTS, and move READY to DRAIN.
REQ-021 Read data, o_port_mask and o_valid SHALL appear exactly one cycle after the accepted ren; o_valid SHALL be 0 in all other cycles.
REQ-022 For any port with rptr+p >= DEPTH, that port's o_ct slice SHALL be 0 and its mask bit SHALL be 0; no RAM address >= DEPTH SHALL be driven.
REQ-023 A read with rptr+READ_PORTS >= DEPTH is the final read; it SHALL clear rptr to 0 and go to FILL, or to READY if replay = 1 in the same cycle.
REQ-024 Replay SHALL leave RAM contents and wptr untouched, so the next drain returns identical data.
REQ-025 wen outside FILL SHALL be ignored (no RAM write) and SHALL set o_overflow.
REQ-026 ren in FILL SHALL be ignored (no o_valid) and SHALL set o_underflow, including in the same cycle as the final FILL write.
REQ-027 wen and ren in the same cycle SHALL each be handled by the rules for the current state, independently.
REQ-028 o_overflow and o_underflow SHALL clear only on reset.
REQ-029 RAM SHALL be simple dual-port, synchronous read, one read port per READ_PORTS instance or an equivalent wide read; read-during-write never occurs by construction of the FSM.
REQ-030 All pointer arithmetic SHALL use ADDR_WIDTH+1 bits so rptr+p comparisons do not wrap.

Reset
REQ-031 While reset = 0: state = FILL, wptr = 0, rptr = 0, o_valid = 0, o_port_mask = 0, o_ct = 0, o_frame_ready = 0, o_overflow = 0, o_underflow = 0.
REQ-032 RAM contents SHALL NOT be reset; a reset mid-FILL or mid-DRAIN SHALL discard the partial frame and require a full refill.
REQ-033 Any read in flight when reset asserts SHALL NOT produce o_valid after reset deasserts.

Verification (defaults: DATA_WIDTH 18, LANES 16, READ_PORTS 2, DEPTH 64)
REQ-034 Fill with word k having every lane = k, then 32 ren -> read j returns ports {2j, 2j+1}, mask = 2'b11, o_valid exactly 1 cycle after each ren; FSM returns to FILL after read 31.
REQ-035 READ_PORTS=3, DEPTH=64, full drain -> read 21 returns word 63 on port 0, ports 1-2 zero, mask = 3'b001.
REQ-036 Final read with replay = 1, then 32 more ren -> identical data sequence, o_frame_ready stays 1, no wen needed.
REQ-037 wen in READY with i_ct = all-ones -> o_overflow = 1, subsequent drain returns original data; ren in FILL -> o_underflow = 1, no o_valid.
REQ-038 Reset pulse after 40 writes -> all outputs 0 immediately; 64 new writes required before o_frame_ready = 1.
REQ-039 Reset asserted the cycle after an accepted ren -> o_valid never rises for that read.

Source files
------------

// File: rtl/ct_frame_buffer_if.sv
// Host-side bundle for ct_frame_buffer: write stream, read requests and drained frame data.
interface ct_frame_buffer_if #(
  parameter int DATA_WIDTH = 18,
  parameter int LANES      = 16,
  parameter int READ_PORTS = 2
);
  logic                                  wen;
  logic [LANES*DATA_WIDTH-1:0]           i_ct;
  logic                                  ren;
  logic                                  replay;
  logic [READ_PORTS*LANES*DATA_WIDTH-1:0] o_ct;
  logic [READ_PORTS-1:0]                 o_port_mask;
  logic                                  o_valid;
  logic                                  o_frame_ready;
  logic                                  o_overflow;
  logic                                  o_underflow;

  modport master (
    output wen, i_ct, ren, replay,
    input  o_ct, o_port_mask, o_valid, o_frame_ready, o_overflow, o_underflow
  );

  modport slave (
    input  wen, i_ct, ren, replay,
    output o_ct, o_port_mask, o_valid, o_frame_ready, o_overflow, o_underflow
  );
endinterface

// File: rtl/ct_frame_buffer.sv
// Single-frame Ct buffer: fill DEPTH words, then drain READ_PORTS consecutive words per read,
// optionally replaying the same frame. One RAM bank per read port.
module ct_fb_bank #(
  parameter int WORD_W     = 288,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int PORT       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WORD_W-1:0]     wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH:0]   rptr,
  output logic [WORD_W-1:0]     rdata,
  output logic                  hit
);
  logic [WORD_W-1:0]     mem [DEPTH];
  logic [ADDR_WIDTH:0]   raddr;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  in_range;

  assign raddr    = rptr + (ADDR_WIDTH+1)'(PORT);
  assign in_range = raddr < (ADDR_WIDTH+1)'(DEPTH);
  // Out-of-range ports park the RAM address at 0 and return zero data.
  assign ram_addr = in_range ? raddr[ADDR_WIDTH-1:0] : '0;

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rdata <= '0;
      hit   <= 1'b0;
    end else if (re) begin
      rdata <= in_range ? mem[ram_addr] : '0;
      hit   <= in_range;
    end
endmodule

module ct_frame_buffer #(
  parameter int DATA_WIDTH = 18,
  parameter int LANES      = 16,
  parameter int READ_PORTS = 2,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic            clk,
  input  logic            reset,
  ct_frame_buffer_if.slave bus
);
  localparam int WORD_W = LANES * DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] RP_STEP   = (ADDR_WIDTH+1)'(READ_PORTS);

  typedef enum logic [1:0] {FILL, READY, DRAIN} state_t;

  state_t                            state, state_nxt;
  logic [ADDR_WIDTH:0]               wptr, wptr_nxt, rptr, rptr_nxt;
  logic                              wr_acc, rd_acc, last_wr, final_rd;
  logic [31:0]                       rptr_end;
  logic                              vld_q, ovf_q, unf_q;
  logic [READ_PORTS-1:0][WORD_W-1:0] rd_data;
  logic [READ_PORTS-1:0]             rd_hit;

  assign wr_acc   = bus.wen && (state == FILL);
  assign rd_acc   = bus.ren && (state != FILL);
  assign last_wr  = wr_acc && (wptr == LAST_ADDR);
  // Widened so the final-read test cannot wrap for any READ_PORTS/DEPTH pair.
  assign rptr_end = 32'(rptr) + 32'(READ_PORTS);
  assign final_rd = rd_acc && (rptr_end >= 32'(DEPTH));

  always_comb begin
    state_nxt = state;
    wptr_nxt  = wptr;
    rptr_nxt  = rptr;
    case (state)
      FILL:
        if (wr_acc) begin
          if (last_wr) begin
            wptr_nxt  = '0;
            state_nxt = READY;
          end else begin
            wptr_nxt = wptr + 1'b1;
          end
        end
      READY, DRAIN:
        if (rd_acc) begin
          if (final_rd) begin
            rptr_nxt  = '0;
            state_nxt = bus.replay ? READY : FILL;
          end else begin
            rptr_nxt  = rptr + RP_STEP;
            state_nxt = DRAIN;
          end
        end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= FILL;
      wptr  <= '0;
      rptr  <= '0;
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      wptr  <= wptr_nxt;
      rptr  <= rptr_nxt;
      vld_q <= rd_acc;
      ovf_q <= ovf_q | (bus.wen && (state != FILL));
      unf_q <= unf_q | (bus.ren && (state == FILL));
    end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_bank
    ct_fb_bank #(
      .WORD_W    (WORD_W),
      .DEPTH     (DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .PORT      (p)
    ) u_bank (
      .clk  (clk),
      .reset(reset),
      .we   (wr_acc),
      .waddr(wptr[ADDR_WIDTH-1:0]),
      .wdata(bus.i_ct),
      .re   (rd_acc),
      .rptr (rptr),
      .rdata(rd_data[p]),
      .hit  (rd_hit[p])
    );
  end

  assign bus.o_ct          = rd_data;
  assign bus.o_port_mask   = rd_hit;
  assign bus.o_valid       = vld_q;
  assign bus.o_frame_ready = (state != FILL);
  assign bus.o_overflow    = ovf_q;
  assign bus.o_underflow   = unf_q;
endmodule

// File: tb/tb_ct_frame_buffer.sv
// Directed bench for ct_frame_buffer: reference model predicts reads into a scoreboard queue,
// popped when the DUT raises o_valid. A second instance covers READ_PORTS=3 tail masking.
module tb_ct_frame_buffer;
  localparam int DW = 18, L = 16, D = 64, AW = 6, W = L * DW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ct_frame_buffer_if #(.DATA_WIDTH(DW), .LANES(L), .READ_PORTS(2)) bus ();
  ct_frame_buffer_if #(.DATA_WIDTH(DW), .LANES(L), .READ_PORTS(3)) bus3 ();

  ct_frame_buffer #(.DATA_WIDTH(DW), .LANES(L), .READ_PORTS(2), .DEPTH(D), .ADDR_WIDTH(AW))
    u_dut (.clk(clk), .reset(reset), .bus(bus));
  ct_frame_buffer #(.DATA_WIDTH(DW), .LANES(L), .READ_PORTS(3), .DEPTH(D), .ADDR_WIDTH(AW))
    u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

  typedef struct packed { logic [2*W-1:0] data; logic [1:0] mask; } exp2_t;
  typedef struct packed { logic [3*W-1:0] data; logic [2:0] mask; } exp3_t;
  exp2_t q2[$];
  exp3_t q3[$];

  int n_vec = 0, n_err = 0;

  // Reference model of the frame buffer behaviour (0 = FILL, 1 = READY, 2 = DRAIN).
  logic [W-1:0] mdl [D];
  int   m_state, m_wptr, m_rptr;
  logic m_ovf, m_unf;

  function automatic logic [W-1:0] word_of(input int k);
    logic [W-1:0] w;
    w = '0;
    for (int n = 0; n < L; n++) w[n*DW +: DW] = DW'(k);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [1023:0] act, input logic [1023:0] exp);
    n_vec++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_wptr = 0; m_rptr = 0; m_ovf = 1'b0; m_unf = 1'b0;
    q2.delete();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " o_valid"},       1024'(bus.o_valid), '0);
    chk({tag, " o_port_mask"},   1024'(bus.o_port_mask), '0);
    chk({tag, " o_ct"},          1024'(bus.o_ct), '0);
    chk({tag, " o_frame_ready"}, 1024'(bus.o_frame_ready), '0);
    chk({tag, " o_overflow"},    1024'(bus.o_overflow), '0);
    chk({tag, " o_underflow"},   1024'(bus.o_underflow), '0);
  endtask

  // One clock of stimulus on the READ_PORTS=2 instance, with model update and output checks.
  task automatic cyc(input logic w, input logic [W-1:0] d, input logic r, input logic rp);
    exp2_t e;
    logic  acc;
    bus.wen = w; bus.i_ct = d; bus.ren = r; bus.replay = rp;
    acc = r && (m_state != 0);
    if (w && m_state != 0) m_ovf = 1'b1;
    if (r && m_state == 0) m_unf = 1'b1;
    if (acc) begin
      e = '0;
      for (int p = 0; p < 2; p++)
        if (m_rptr + p < D) begin
          e.data[p*W +: W] = mdl[m_rptr + p];
          e.mask[p] = 1'b1;
        end
      q2.push_back(e);
      if (m_rptr + 2 >= D) begin
        m_rptr = 0;
        m_state = rp ? 1 : 0;
      end else begin
        m_rptr += 2;
        m_state = 2;
      end
    end else if (w && m_state == 0) begin
      mdl[m_wptr] = d;
      if (m_wptr == D - 1) begin
        m_wptr = 0;
        m_state = 1;
      end else m_wptr++;
    end
    @(posedge clk);
    @(negedge clk);
    chk("o_valid", 1024'(bus.o_valid), 1024'(acc));
    if (bus.o_valid === 1'b1) begin
      chk("scoreboard depth", 1024'(q2.size() > 0), 1024'(1'b1));
      if (q2.size() > 0) begin
        e = q2.pop_front();
        chk("o_ct", 1024'(bus.o_ct), 1024'(e.data));
        chk("o_port_mask", 1024'(bus.o_port_mask), 1024'(e.mask));
      end
    end
    chk("o_frame_ready", 1024'(bus.o_frame_ready), 1024'(m_state != 0));
    chk("o_overflow", 1024'(bus.o_overflow), 1024'(m_ovf));
    chk("o_underflow", 1024'(bus.o_underflow), 1024'(m_unf));
    bus.wen = 1'b0; bus.ren = 1'b0; bus.replay = 1'b0;
  endtask

  initial begin
    exp3_t e3;
    logic [W-1:0] ones;
    ones = '1;
    bus.wen = 1'b0; bus.i_ct = '0; bus.ren = 1'b0; bus.replay = 1'b0;
    bus3.wen = 1'b0; bus3.i_ct = '0; bus3.ren = 1'b0; bus3.replay = 1'b0;
    for (int k = 0; k < D; k++) mdl[k] = '0;
    model_reset();

    #12;
    chk_zero_outputs("reset");
    @(negedge clk) reset = 1'b1;

    // ren in FILL is ignored and flags underflow
    cyc(1'b0, '0, 1'b1, 1'b0);

    // fill words 0..63; ren alongside the final write is still an underflow
    for (int k = 0; k < D - 1; k++) cyc(1'b1, word_of(k), 1'b0, 1'b0);
    cyc(1'b1, word_of(D - 1), 1'b1, 1'b0);

    // full drain, replay on the final read
    for (int j = 0; j < D / 2; j++) cyc(1'b0, '0, 1'b1, j == D / 2 - 1);

    // write while READY: ignored, sets overflow
    cyc(1'b1, ones, 1'b0, 1'b0);

    // replayed drain, no replay at the end -> back to FILL
    for (int j = 0; j < D / 2; j++) cyc(1'b0, '0, 1'b1, 1'b0);

    // partial frame then reset: outputs clear immediately
    for (int k = 0; k < 40; k++) cyc(1'b1, word_of(k + 100), 1'b0, 1'b0);
    @(negedge clk) reset = 1'b0;
    #1;
    chk_zero_outputs("mid-fill reset");
    @(negedge clk) reset = 1'b1;
    model_reset();

    // a full 64-word refill is needed before frame_ready
    for (int k = 0; k < D; k++) cyc(1'b1, word_of(k + 200), 1'b0, 1'b0);
    for (int j = 0; j < 5; j++) cyc(1'b0, '0, 1'b1, 1'b0);

    // read request caught by reset before it can complete: no o_valid afterwards
    bus.ren = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("o_valid under reset", 1024'(bus.o_valid), '0);
    bus.ren = 1'b0;
    reset = 1'b1;
    model_reset();
    for (int j = 0; j < 3; j++) cyc(1'b0, '0, 1'b0, 1'b0);

    // READ_PORTS=3 instance: tail read carries only word 63
    for (int k = 0; k < D; k++) begin
      bus3.wen = 1'b1; bus3.i_ct = word_of(k + 7);
      @(posedge clk);
      @(negedge clk);
    end
    bus3.wen = 1'b0;
    chk("rp3 frame_ready", 1024'(bus3.o_frame_ready), 1024'(1'b1));
    for (int j = 0; j < 22; j++) begin
      e3 = '0;
      for (int p = 0; p < 3; p++)
        if (3 * j + p < D) begin
          e3.data[p*W +: W] = word_of(3 * j + p + 7);
          e3.mask[p] = 1'b1;
        end
      q3.push_back(e3);
      bus3.ren = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rp3 o_valid", 1024'(bus3.o_valid), 1024'(1'b1));
      if (bus3.o_valid === 1'b1 && q3.size() > 0) begin
        e3 = q3.pop_front();
        chk("rp3 o_ct", 1024'(bus3.o_ct), 1024'(e3.data));
        chk("rp3 o_port_mask", 1024'(bus3.o_port_mask), 1024'(e3.mask));
      end
    end
    bus3.ren = 1'b0;
    chk("rp3 back to FILL", 1024'(bus3.o_frame_ready), '0);
    @(posedge clk);
    @(negedge clk);
    chk("rp3 o_valid idle", 1024'(bus3.o_valid), '0);
    chk("rp3 leftover", 1024'(q3.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
